react_judge: RTL and testbench
==============================

# react_judge

Parametrised multi-player reaction-game judge: the next generation of the single-player reaction state machine. Sequences arm, random-delay, react-window and result phases for `N_PLAYER` react buttons over `ROUNDS` rounds, detects false starts and too-fast presses per player, picks the round winner and the game champion, and tracks best time. Sits between the button debouncers, random-delay counter and main reaction-time counter, and drives the display controller.

## Interface
- `N_PLAYER`, 2: number of react inputs, 1..8.
- `TIME_W`, 16: width of `act_time` and the time outputs.
- `MIN_TIME`, 256: minimum valid reaction count; faster presses are fouls.
- `ROUNDS`, 3: rounds per game, 1..15.
- Derived: `PID_W = max(1, $clog2(N_PLAYER))`; `RND_W = $clog2(ROUNDS+1)`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `start` input 1: start/next pulse, one cycle, debounced.
- `react` input N_PLAYER: per-player react pulses, one cycle each.
- `rand_done` input 1: random delay elapsed.
- `time_out` input 1: react window expired.
- `act_time` input TIME_W: main counter value, counting since WAIT entry.
- `state` output 3: IDLE=000, ARM=001, FAIL=010, WAIT=011, ROUND_END=111, GAME_END=100.
- `timer_clr` output 1: one-cycle pulse on every entry into ARM or WAIT.
- `foul` output N_PLAYER: per-player foul flags for the current round.
- `winner` output PID_W: round winner index.
- `win_time` output TIME_W: winner's `act_time`.
- `round_cnt` output RND_W: rounds completed in the current game.
- `champion` output PID_W: player with the most round wins; valid in GAME_END.
- `best_time` output TIME_W: fastest valid win this game.

## Operation
- IDLE: `start` -> ARM. Clear `foul`, `round_cnt`, win counters, `winner`, `win_time`. Set `best_time` to all ones.
- ARM: `react[i]` sets `foul[i]`.
  - All bits of `foul` set -> FAIL.
  - Else `rand_done` -> WAIT.
  - If `react` and `rand_done` arrive in the same cycle, the press counts as a foul first. The WAIT transition is taken only if at least one player is still unfouled.
- WAIT: a player is eligible if `foul[i]`=0.
  - Eligible press with `act_time < MIN_TIME` sets `foul[i]`.
  - Eligible press with `act_time >= MIN_TIME` is a valid hit.
  - Priority, highest first:
    - `time_out` -> FAIL. This wins over a simultaneous valid hit.
    - Any valid hit -> ROUND_END. Lowest index wins ties. Latch `winner` and `win_time`, and increment that player's win counter.
    - All players fouled -> FAIL.
    - Else hold.
- ROUND_END and FAIL:
  - `round_cnt` increments on entry.
  - `best_time` is updated on ROUND_END entry if `win_time` is strictly smaller.
  - The state holds until `start`.
  - On `start`: if `round_cnt < ROUNDS`, go to ARM with `foul` cleared. Else go to GAME_END.
- GAME_END: `champion` is registered on entry.
  - Most wins; ties go to the lowest index.
  - If nobody won, `champion`=0.
  - `start` -> ARM, starting a fresh game with the same clears as leaving IDLE.
- IDLE is re-entered only through reset.
- Inputs arriving in states that do not use them are ignored. Multiple simultaneous `react` bits are each evaluated independently.
- Win counters are RND_W bits wide and never exceed ROUNDS.

## Timing
- All outputs are registered.
- Every decision takes effect on the `clk` edge where its input is sampled high, so the state changes 1 cycle after the input edge.
- `timer_clr` is high during the first cycle the new state (ARM or WAIT) is visible.
- `winner`, `win_time` and `foul` update in the same cycle `state` changes.
- `champion` is valid in the first GAME_END cycle.
- Reset asserted at any time, including mid-round, forces the following immediately:
  - `state`=IDLE
  - `timer_clr`=0, `foul`=0, `winner`=0, `win_time`=0
  - `round_cnt`=0, `champion`=0
  - `best_time`=all ones
- Deassertion is synchronised outside this block.

## Configuration
- `REACT_BEST_TIME_EN`:
  - Defined: the `best_time` register and its compare logic are built as described above.
  - Undefined: `best_time` is tied to all ones and no compare logic is built. All other behaviour is identical.

## Test plan
- Single round, valid hit: `start`, `rand_done`, then `react`=01 at `act_time`=300. Expect the state sequence ARM->WAIT->ROUND_END, `winner`=0, `win_time`=300, `round_cnt`=1, and `timer_clr` pulses at ARM entry and at WAIT entry.
- False start: `react`=10 in ARM, then `rand_done`, then `react`=01 at 400. Expect `foul`=10, `winner`=0. A second `react`=10 while in WAIT is ignored.
- Too fast: both players press at `act_time`=100 -> both fouled -> FAIL. Boundary check: a press at exactly 256 is a valid hit -> ROUND_END.
- Simultaneous events: `time_out` and a valid `react` in the same cycle -> FAIL. `react`=11 at 500 -> `winner`=0.
- Full game, ROUNDS=3: wins by P1, P0, P1 at 900, 600, 700 -> after the third `start`, GAME_END with `champion`=1 and `best_time`=600. With the macro undefined, `best_time`=FFFF.
- Reset mid-WAIT: assert `rst_n`=0 with no clock edge -> all outputs take their reset values immediately. After release, `start` begins round 1 with `round_cnt`=0.

Source files
------------

// File: rtl/react_judge_if.sv
// react_judge_if
//   Bundles the judge's game-side inputs and display-side outputs.
//   Parameters mirror react_judge: N_PLAYER, TIME_W, ROUNDS.
//   Modports:
//     master : drives start/react/rand_done/time_out/act_time, observes results
//     slave  : the judge itself (consumes inputs, drives results)
//   Signals:
//     start, react[N_PLAYER], rand_done, time_out, act_time[TIME_W]   -> judge
//     state[3], timer_clr, foul[N_PLAYER], winner[PID_W],
//     win_time[TIME_W], round_cnt[RND_W], champion[PID_W],
//     best_time[TIME_W]                                              <- judge
interface react_judge_if #(
  parameter int N_PLAYER = 2,
  parameter int TIME_W   = 16,
  parameter int ROUNDS   = 3
);
  localparam int PID_W = (N_PLAYER > 1) ? $clog2(N_PLAYER) : 1;
  localparam int RND_W = $clog2(ROUNDS + 1);

  logic                start;
  logic [N_PLAYER-1:0] react;
  logic                rand_done;
  logic                time_out;
  logic [TIME_W-1:0]   act_time;

  logic [2:0]          state;
  logic                timer_clr;
  logic [N_PLAYER-1:0] foul;
  logic [PID_W-1:0]    winner;
  logic [TIME_W-1:0]   win_time;
  logic [RND_W-1:0]    round_cnt;
  logic [PID_W-1:0]    champion;
  logic [TIME_W-1:0]   best_time;

  modport master (
    output start, react, rand_done, time_out, act_time,
    input  state, timer_clr, foul, winner, win_time, round_cnt, champion, best_time
  );

  modport slave (
    input  start, react, rand_done, time_out, act_time,
    output state, timer_clr, foul, winner, win_time, round_cnt, champion, best_time
  );
endinterface

// File: rtl/react_judge.sv
// react_judge
//   Multi-player reaction-game judge. Sequences ARM -> WAIT -> ROUND_END/FAIL
//   for N_PLAYER react buttons over ROUNDS rounds, flags false starts and
//   too-fast presses per player, latches the round winner, picks the game
//   champion and (optionally) tracks the best winning time.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous reset, active low
//     bus    : react_judge_if.slave (inputs start/react/rand_done/time_out/
//              act_time; registered outputs state/timer_clr/foul/winner/
//              win_time/round_cnt/champion/best_time)
//   Build option:
//     REACT_BEST_TIME_EN : when defined, best_time is a register updated on
//                          every winning round; otherwise tied to all ones.
module react_judge #(
  parameter int N_PLAYER = 2,
  parameter int TIME_W   = 16,
  parameter int MIN_TIME = 256,
  parameter int ROUNDS   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  react_judge_if.slave  bus
);
  localparam int PID_W = (N_PLAYER > 1) ? $clog2(N_PLAYER) : 1;
  localparam int RND_W = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_ARM       = 3'b001,
    S_FAIL      = 3'b010,
    S_WAIT      = 3'b011,
    S_ROUND_END = 3'b111,
    S_GAME_END  = 3'b100
  } state_t;

  state_t               state_reg;
  logic                 timer_clr_reg;
  logic [N_PLAYER-1:0]  foul_reg;
  logic [PID_W-1:0]     winner_reg;
  logic [TIME_W-1:0]    win_time_reg;
  logic [RND_W-1:0]     round_cnt_reg;
  logic [PID_W-1:0]     champion_reg;
  logic [N_PLAYER*RND_W-1:0] win_cnt_flat;

  // Per-press classification. In ARM every press is a foul; in WAIT only
  // presses from still-unfouled players count, split by the MIN_TIME limit.
  logic [N_PLAYER-1:0] arm_foul;
  logic [N_PLAYER-1:0] eligible;
  logic [N_PLAYER-1:0] early;
  logic [N_PLAYER-1:0] hit;
  logic [N_PLAYER-1:0] wait_foul;
  logic                too_fast;
  logic [PID_W-1:0]    hit_idx;
  logic [PID_W-1:0]    champ_idx;
  logic [RND_W-1:0]    champ_best;
  logic                new_game;
  logic                win_fire;
  logic                more_rounds;

  assign arm_foul    = foul_reg | bus.react;
  assign eligible    = bus.react & ~foul_reg;
  assign too_fast    = bus.act_time < TIME_W'(MIN_TIME);
  assign early       = too_fast ? eligible : '0;
  assign hit         = too_fast ? '0 : eligible;
  assign wait_foul   = foul_reg | early;
  assign new_game    = bus.start && (state_reg == S_IDLE || state_reg == S_GAME_END);
  // time_out outranks a simultaneous valid hit, so it blocks the win.
  assign win_fire    = (state_reg == S_WAIT) && !bus.time_out && (|hit);
  assign more_rounds = round_cnt_reg < RND_W'(ROUNDS);

  // Lowest index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit_idx = '0;
    for (int i = N_PLAYER - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = PID_W'(i);
    end
  end

  // Strictly-greater compare keeps the lowest index on ties; no wins -> 0.
  always_comb begin
    champ_idx  = '0;
    champ_best = '0;
    for (int i = 0; i < N_PLAYER; i++) begin
      if (win_cnt_flat[i*RND_W +: RND_W] > champ_best) begin
        champ_best = win_cnt_flat[i*RND_W +: RND_W];
        champ_idx  = PID_W'(i);
      end
    end
  end

  // Per-player win counters; at most one increments per round, so they
  // can never exceed ROUNDS.
  for (genvar gi = 0; gi < N_PLAYER; gi++) begin : g_win
    logic [RND_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (new_game) begin
        cnt_reg <= '0;
      end else if (win_fire && hit_idx == PID_W'(gi)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign win_cnt_flat[gi*RND_W +: RND_W] = cnt_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      timer_clr_reg <= 1'b0;
      foul_reg      <= '0;
      winner_reg    <= '0;
      win_time_reg  <= '0;
      round_cnt_reg <= '0;
      champion_reg  <= '0;
    end else begin
      timer_clr_reg <= 1'b0;
      unique case (state_reg)
        S_IDLE, S_GAME_END: begin
          if (bus.start) begin
            state_reg     <= S_ARM;
            timer_clr_reg <= 1'b1;
            foul_reg      <= '0;
            round_cnt_reg <= '0;
            winner_reg    <= '0;
            win_time_reg  <= '0;
          end
        end
        S_ARM: begin
          // Presses are folded in before rand_done is considered, so a
          // same-cycle press still counts as a false start.
          foul_reg <= arm_foul;
          if (&arm_foul) begin
            state_reg     <= S_FAIL;
            round_cnt_reg <= round_cnt_reg + 1'b1;
          end else if (bus.rand_done) begin
            state_reg     <= S_WAIT;
            timer_clr_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          foul_reg <= wait_foul;
          if (bus.time_out) begin
            state_reg     <= S_FAIL;
            round_cnt_reg <= round_cnt_reg + 1'b1;
          end else if (|hit) begin
            state_reg     <= S_ROUND_END;
            winner_reg    <= hit_idx;
            win_time_reg  <= bus.act_time;
            round_cnt_reg <= round_cnt_reg + 1'b1;
          end else if (&wait_foul) begin
            state_reg     <= S_FAIL;
            round_cnt_reg <= round_cnt_reg + 1'b1;
          end
        end
        S_FAIL, S_ROUND_END: begin
          if (bus.start) begin
            if (more_rounds) begin
              state_reg     <= S_ARM;
              timer_clr_reg <= 1'b1;
              foul_reg      <= '0;
            end else begin
              state_reg    <= S_GAME_END;
              champion_reg <= champ_idx;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef REACT_BEST_TIME_EN
  logic [TIME_W-1:0] best_time_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_time_reg <= '1;
    end else if (new_game) begin
      best_time_reg <= '1;
    end else if (win_fire && bus.act_time < best_time_reg) begin
      best_time_reg <= bus.act_time;
    end
  end
  assign bus.best_time = best_time_reg;
`else
  assign bus.best_time = '1;
`endif

  assign bus.state     = state_reg;
  assign bus.timer_clr = timer_clr_reg;
  assign bus.foul      = foul_reg;
  assign bus.winner    = winner_reg;
  assign bus.win_time  = win_time_reg;
  assign bus.round_cnt = round_cnt_reg;
  assign bus.champion  = champion_reg;
endmodule

// File: tb/tb_react_judge.sv
// tb_react_judge
//   Directed scenarios followed by randomized play, each cycle compared
//   against a behavioural game model held in the bench.
module tb_react_judge;
  localparam int N    = 2;
  localparam int TW   = 16;
  localparam int MIN  = 256;
  localparam int RNDS = 3;
  localparam int ALL_ONES = (1 << TW) - 1;
  localparam int ALL_FOUL = (1 << N) - 1;
`ifdef REACT_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_ARM = 1, ST_FAIL = 2, ST_WAIT = 3, ST_RE = 7, ST_GE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  react_judge_if #(.N_PLAYER(N), .TIME_W(TW), .ROUNDS(RNDS)) bus ();

  react_judge #(.N_PLAYER(N), .TIME_W(TW), .MIN_TIME(MIN), .ROUNDS(RNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Game model: plain integers describing the score sheet.
  int m_state, m_clr, m_foul, m_winner, m_win_time, m_round, m_champ, m_best;
  int m_wins[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_clr = 0; m_foul = 0; m_winner = 0; m_win_time = 0;
    m_round = 0; m_champ = 0; m_best = ALL_ONES;
    for (int i = 0; i < N; i++) m_wins[i] = 0;
  endtask

  task automatic model_step(input int st, input int rc, input int rd, input int to, input int at);
    int win;
    int top;
    win   = -1;
    m_clr = 0;
    case (m_state)
      ST_IDLE, ST_GE: begin
        if (st != 0) begin
          m_state = ST_ARM; m_clr = 1; m_foul = 0; m_round = 0;
          m_winner = 0; m_win_time = 0; m_best = ALL_ONES;
          for (int i = 0; i < N; i++) m_wins[i] = 0;
        end
      end
      ST_ARM: begin
        m_foul = m_foul | rc;
        if (m_foul == ALL_FOUL) begin
          m_state = ST_FAIL; m_round++;
        end else if (rd != 0) begin
          m_state = ST_WAIT; m_clr = 1;
        end
      end
      ST_WAIT: begin
        for (int i = 0; i < N; i++) begin
          if (((rc >> i) & 1) == 1 && ((m_foul >> i) & 1) == 0) begin
            if (at < MIN) m_foul = m_foul | (1 << i);
            else if (win < 0) win = i;
          end
        end
        if (to != 0) begin
          m_state = ST_FAIL; m_round++;
        end else if (win >= 0) begin
          m_state = ST_RE; m_winner = win; m_win_time = at; m_wins[win]++; m_round++;
          if (BEST_EN && at < m_best) m_best = at;
        end else if (m_foul == ALL_FOUL) begin
          m_state = ST_FAIL; m_round++;
        end
      end
      default: begin // ST_FAIL, ST_RE
        if (st != 0) begin
          if (m_round < RNDS) begin
            m_state = ST_ARM; m_foul = 0; m_clr = 1;
          end else begin
            m_state = ST_GE;
            top = 0; m_champ = 0;
            for (int i = 0; i < N; i++)
              if (m_wins[i] > top) begin top = m_wins[i]; m_champ = i; end
          end
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"},     32'(bus.state),     m_state);
    check({tag, ".timer_clr"}, 32'(bus.timer_clr), m_clr);
    check({tag, ".foul"},      32'(bus.foul),      m_foul);
    check({tag, ".winner"},    32'(bus.winner),    m_winner);
    check({tag, ".win_time"},  32'(bus.win_time),  m_win_time);
    check({tag, ".round_cnt"}, 32'(bus.round_cnt), m_round);
    check({tag, ".champion"},  32'(bus.champion),  m_champ);
    check({tag, ".best_time"}, 32'(bus.best_time), m_best);
  endtask

  task automatic cycle(input string tag, input bit st, input logic [N-1:0] rc,
                       input bit rd, input bit to, input int at);
    int prev;
    @(negedge clk);
    bus.start = st; bus.react = rc; bus.rand_done = rd; bus.time_out = to;
    bus.act_time = TW'(at);
    prev = m_state;
    model_step(int'(st), int'(rc), int'(rd), int'(to), at);
    @(posedge clk);
    #1;
    compare_all(tag);
    if (m_state != prev && (m_state == ST_RE || m_state == ST_FAIL || m_state == ST_GE))
      $display("%s: state=%0d winner=%0d win_time=%0d round=%0d foul=%0d champion=%0d best=%0d",
               tag, bus.state, bus.winner, bus.win_time, bus.round_cnt, bus.foul,
               bus.champion, bus.best_time);
  endtask

  // Asynchronous reset: outputs must change with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".state"},     32'(bus.state),     ST_IDLE);
    check({tag, ".timer_clr"}, 32'(bus.timer_clr), 0);
    check({tag, ".foul"},      32'(bus.foul),      0);
    check({tag, ".winner"},    32'(bus.winner),    0);
    check({tag, ".win_time"},  32'(bus.win_time),  0);
    check({tag, ".round_cnt"}, 32'(bus.round_cnt), 0);
    check({tag, ".champion"},  32'(bus.champion),  0);
    check({tag, ".best_time"}, 32'(bus.best_time), ALL_ONES);
    model_reset();
    $display("%s: reset applied", tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rc;
    int r, at;
    bus.start = 1'b0; bus.react = '0; bus.rand_done = 1'b0; bus.time_out = 1'b0;
    bus.act_time = '0;
    rst_n = 1'b1;
    model_reset();
    #1;
    async_reset("por");

    // Single round, valid hit
    cycle("t1", 1, 2'b00, 0, 0, 0);
    check("t1.arm", 32'(bus.state), ST_ARM);
    check("t1.clr_arm", 32'(bus.timer_clr), 1);
    cycle("t1", 0, 2'b00, 1, 0, 0);
    check("t1.wait", 32'(bus.state), ST_WAIT);
    check("t1.clr_wait", 32'(bus.timer_clr), 1);
    cycle("t1", 0, 2'b01, 0, 0, 300);
    check("t1.re", 32'(bus.state), ST_RE);
    check("t1.winner", 32'(bus.winner), 0);
    check("t1.time", 32'(bus.win_time), 300);
    check("t1.round", 32'(bus.round_cnt), 1);
    check("t1.clr_low", 32'(bus.timer_clr), 0);

    // False start, then ignored repeat press in WAIT
    cycle("t2", 1, 2'b00, 0, 0, 0);
    cycle("t2", 0, 2'b10, 0, 0, 0);
    check("t2.foul_arm", 32'(bus.foul), 2);
    cycle("t2", 0, 2'b00, 1, 0, 0);
    cycle("t2", 0, 2'b10, 0, 0, 50);
    check("t2.ignored", 32'(bus.state), ST_WAIT);
    cycle("t2", 0, 2'b01, 0, 0, 400);
    check("t2.winner", 32'(bus.winner), 0);
    check("t2.foul", 32'(bus.foul), 2);
    check("t2.round", 32'(bus.round_cnt), 2);

    // Too fast: both fouled -> fail, then third start ends the game
    cycle("t3", 1, 2'b00, 0, 0, 0);
    cycle("t3", 0, 2'b00, 1, 0, 0);
    cycle("t3", 0, 2'b11, 0, 0, 100);
    check("t3.fail", 32'(bus.state), ST_FAIL);
    check("t3.foul", 32'(bus.foul), 3);
    cycle("t3", 1, 2'b00, 0, 0, 0);
    check("t3.ge", 32'(bus.state), ST_GE);
    check("t3.champ", 32'(bus.champion), 0);
    check("t3.best", 32'(bus.best_time), BEST_EN ? 300 : ALL_ONES);

    // Boundary: 255 fouls, 256 wins
    cycle("t4", 1, 2'b00, 0, 0, 0);
    check("t4.round0", 32'(bus.round_cnt), 0);
    cycle("t4", 0, 2'b00, 1, 0, 0);
    cycle("t4", 0, 2'b10, 0, 0, 255);
    check("t4.foul255", 32'(bus.foul), 2);
    cycle("t4", 0, 2'b01, 0, 0, 256);
    check("t4.re256", 32'(bus.state), ST_RE);
    check("t4.time256", 32'(bus.win_time), 256);

    // time_out beats a valid hit; tie goes to player 0
    cycle("t5", 1, 2'b00, 0, 0, 0);
    cycle("t5", 0, 2'b00, 1, 0, 0);
    cycle("t5", 0, 2'b01, 0, 1, 500);
    check("t5.tofail", 32'(bus.state), ST_FAIL);
    cycle("t5", 1, 2'b00, 0, 0, 0);
    cycle("t5", 0, 2'b00, 1, 0, 0);
    cycle("t5", 0, 2'b11, 0, 0, 500);
    check("t5.tie", 32'(bus.winner), 0);
    cycle("t5", 1, 2'b00, 0, 0, 0);
    check("t5.ge", 32'(bus.state), ST_GE);

    // Full game: P1 @900, P0 @600, P1 @700 (round 1 also has a same-cycle
    // press + rand_done in ARM)
    cycle("t6", 1, 2'b00, 0, 0, 0);
    cycle("t6", 0, 2'b01, 1, 0, 0);
    check("t6.armfoul", 32'(bus.foul), 1);
    check("t6.armwait", 32'(bus.state), ST_WAIT);
    cycle("t6", 0, 2'b10, 0, 0, 900);
    cycle("t6", 1, 2'b00, 0, 0, 0);
    cycle("t6", 0, 2'b00, 1, 0, 0);
    cycle("t6", 0, 2'b01, 0, 0, 600);
    cycle("t6", 1, 2'b00, 0, 0, 0);
    cycle("t6", 0, 2'b00, 1, 0, 0);
    cycle("t6", 0, 2'b10, 0, 0, 700);
    cycle("t6", 1, 2'b00, 0, 0, 0);
    check("t6.ge", 32'(bus.state), ST_GE);
    check("t6.champ", 32'(bus.champion), 1);
    check("t6.best", 32'(bus.best_time), BEST_EN ? 600 : ALL_ONES);

    // Reset mid-WAIT, then a fresh first round
    cycle("t7", 1, 2'b00, 0, 0, 0);
    cycle("t7", 0, 2'b00, 1, 0, 0);
    check("t7.wait", 32'(bus.state), ST_WAIT);
    async_reset("t7rst");
    cycle("t7", 1, 2'b00, 0, 0, 0);
    check("t7.arm", 32'(bus.state), ST_ARM);
    check("t7.round0", 32'(bus.round_cnt), 0);

    // Randomized play
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) rc[i] = ($urandom_range(0, 4) == 0);
      r = int'($urandom_range(0, 9));
      at = (r == 0) ? MIN - 1 : (r == 1) ? MIN : int'($urandom_range(0, 1200));
      cycle("rnd", $urandom_range(0, 4) == 0, rc, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, at);
      if (k == 1500) async_reset("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
